// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the fetch sequencer.
// Holds the FSM state enum, width/reset-PC defaults and PC step.
package fetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    FLUSH
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry {pc, inst} buffer toward decode.
// Ports: clk, rst_n, push/wdata, pop/rdata, clear, count, full, empty.
module fetch_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          clear,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot for a push
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC owner, imem req/gnt/rvalid sequencer, redirect.
// Ports: CLK, RESET_N, imem_*, inst_*, redirect_*; FETCH_PERF_EN adds
// perf_redirect_cnt and perf_stall_cnt.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int              BUF_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RESET_N,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_redirect_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  state_t          state;
  state_t          state_nx;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nx;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            outstanding;
  logic            issue;
  logic            push;
  logic [2*XLEN-1:0] rdata;
  logic            unused_tgt;

  assign unused_tgt  = ^redirect_target[1:0];
  assign target      = {redirect_target[XLEN-1:2], 2'b00};
  assign outstanding = (state == WAIT) || (state == FLUSH);

  assign imem_req  = (state == FETCH) && !full &&
                     ((int'(count) + int'(outstanding)) < BUF_DEPTH);
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;

  // redirect kills a response arriving in the same cycle
  assign push = (state == WAIT) && imem_rvalid && !redirect_valid;

  assign inst_valid = !empty;
  assign inst_pc    = rdata[2*XLEN-1:XLEN];
  assign inst       = rdata[XLEN-1:0];

  fetch_fifo #(
    .W     (2 * XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (push),
    .wdata ({out_pc, imem_rdata}),
    .pop   (inst_ready),
    .clear (redirect_valid),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    unique case (state)
      BOOT:  state_nx = FETCH;
      FETCH: begin
        if (issue) begin
          state_nx    = WAIT;
          fetch_pc_nx = fetch_pc + XLEN'(PC_INC);
        end
      end
      WAIT:  if (imem_rvalid) state_nx = FETCH;
      FLUSH: if (imem_rvalid) state_nx = FETCH;
      default: state_nx = BOOT;
    endcase
    if (redirect_valid) begin
      fetch_pc_nx = target;
      // still owed a response -> swallow it in FLUSH
      if ((outstanding && !imem_rvalid) || issue) begin
        state_nx = FLUSH;
      end else begin
        state_nx = FETCH;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      out_pc   <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      if (issue) begin
        out_pc <= fetch_pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      perf_redirect_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (redirect_valid && (perf_redirect_cnt != '1)) begin
        perf_redirect_cnt <= perf_redirect_cnt + 1'b1;
      end
      if (!inst_valid && (state != BOOT) &&
          (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
    end
  end
`else
  // no performance counters in this build
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
// Responsive imem model, pc scoreboard, redirect vector table.
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        imem_req, req2;
  logic [31:0] imem_addr, addr2;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid, valid2;
  logic [31:0] inst, inst2;
  logic [31:0] inst_pc, pc2;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
`ifdef FETCH_PERF_EN
  logic [31:0] prc1, psc1, prc2, psc2;
`endif

  always #5 CLK = ~CLK;

  fetch_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target)
`ifdef FETCH_PERF_EN
    , .perf_redirect_cnt(prc1)
    , .perf_stall_cnt(psc1)
`endif
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N),
    .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(valid2), .inst(inst2),
    .inst_pc(pc2), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target)
`ifdef FETCH_PERF_EN
    , .perf_redirect_cnt(prc2)
    , .perf_stall_cnt(psc2)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  typedef struct {
    logic [31:0] target;
    logic        gnt;
    logic [31:0] exp_addr;
    logic        exp_req;
  } vec_t;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] exp_q[$];
  ent_t        q2[$];
  bit          chk2;

  // imem model state
  bit          gnt_en;
  int          lat;
  bit          pend;
  int          wcnt;
  logic [31:0] paddr;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // one clock: score consumptions, cross the edge, drive imem
  task automatic tick();
    logic [31:0] e;
    ent_t        e2;
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_pop: got pc %h want none", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", inst_pc, e);
        check("pop_inst", inst, f(e));
      end
    end
    if (chk2 && valid2 && inst_ready) begin
      if (q2.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_pop2: got pc %h want none", pc2);
      end else begin
        e2 = q2.pop_front();
        check("pop_pc2", pc2, e2.pc);
        check("pop_inst2", inst2, e2.ins);
      end
    end
    @(negedge CLK);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (pend) begin
      if (wcnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = f(paddr);
        pend        = 1'b0;
      end else begin
        wcnt--;
      end
    end
    if (imem_req && gnt_en) begin
      imem_gnt = 1'b1;
      pend     = 1'b1;
      paddr    = imem_addr;
      wcnt     = lat - 1;
    end
  endtask

  task automatic do_reset();
    RESET_N         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    inst_ready      = 1'b0;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = '0;
    pend            = 1'b0;
    gnt_en          = 1'b0;
    lat             = 1;
    chk2            = 1'b0;
    exp_q.delete();
    q2.delete();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_addr2"}, addr2, 32'hFFFF_FFFC);
    check({tag, "_valid"}, inst_valid, 0);
    check({tag, "_inst"}, inst, 32'h0);
    check({tag, "_pc"}, inst_pc, 32'h0);
`ifdef FETCH_PERF_EN
    check({tag, "_prc"}, prc1, 32'h0);
    check({tag, "_psc"}, psc1, 32'h0);
`endif
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || (chk2 && q2.size() != 0)) &&
           n < budget) begin
      tick();
      n++;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'h0);
    inst_ready = 1'b0;
  endtask

  vec_t vt[6];
  int   first_req;
  int   first_valid;
  int   bad_req;
  int   bad_hold;

  initial begin
    vt[0] = '{32'h0000_0103, 1'b0, 32'h0000_0100, 1'b1};
    vt[1] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 1'b1};
    vt[2] = '{32'h0000_0002, 1'b1, 32'h0000_0000, 1'b0};
    vt[3] = '{32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1};
    vt[4] = '{32'h8000_0001, 1'b1, 32'h8000_0000, 1'b0};
    vt[5] = '{32'hABCD_EF0E, 1'b0, 32'hABCD_EF0C, 1'b1};

    // reset state
    RESET_N         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    inst_ready      = 1'b0;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = '0;
    repeat (2) @(negedge CLK);
    chk_reset_vals("rst");

    // streaming: grant all, 1-cycle response, decode always ready
    do_reset();
    gnt_en     = 1'b1;
    inst_ready = 1'b1;
    chk2       = 1'b1;
    exp_q      = '{32'h0, 32'h4, 32'h8, 32'hC};
    q2.push_back('{32'hFFFF_FFFC, f(32'h0)});
    q2.push_back('{32'h0000_0000, f(32'h4)});
    q2.push_back('{32'h0000_0004, f(32'h8)});
    q2.push_back('{32'h0000_0008, f(32'hC)});
    first_req   = -1;
    first_valid = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin
        check("boot_req2", req2, 1);
        check("boot_addr2", addr2, 32'hFFFF_FFFC);
      end
      if (first_req < 0 && imem_req) first_req = k;
      if (first_valid < 0 && inst_valid) first_valid = k;
      if (exp_q.size() == 0 && q2.size() == 0) break;
    end
    check("first_req_cyc", 32'(first_req), 32'd1);
    check("first_valid_cyc", 32'(first_valid), 32'd3);
    check("stream_left2", 32'(q2.size()), 32'h0);
    check("stream_left", 32'(exp_q.size()), 32'h0);
    chk2       = 1'b0;
    inst_ready = 1'b0;

    // backpressure: decode stalls for 10 cycles
    do_reset();
    gnt_en   = 1'b1;
    bad_req  = 0;
    bad_hold = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 5 && imem_req) bad_req++;
      if (k >= 3 && (!inst_valid || inst_pc !== 32'h0 ||
                     inst !== f(32'h0))) bad_hold++;
    end
    check("full_no_req", 32'(bad_req), 32'h0);
    check("full_hold", 32'(bad_hold), 32'h0);
    exp_q      = '{32'h0, 32'h4};
    inst_ready = 1'b1;
    drain("bp_drain", 20);

    // redirect while a response is still owed
    do_reset();
    gnt_en     = 1'b1;
    lat        = 2;
    inst_ready = 1'b1;
    tick();
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check("flush_req", imem_req, 0);
    check("flush_valid", inst_valid, 0);
    tick();
    check("flush_exit_req", imem_req, 1);
    check("flush_exit_addr", imem_addr, 32'h0000_0100);
    exp_q = '{32'h100, 32'h104};
    drain("flush_drain", 30);

    // redirect coincides with rvalid and a head consumption
    do_reset();
    gnt_en = 1'b1;
    lat    = 1;
    repeat (4) tick();
    check("rr_pre_valid", inst_valid, 1);
    check("rr_pre_rvalid", imem_rvalid, 1);
    exp_q           = '{32'h0};
    inst_ready      = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    check("rr_valid", inst_valid, 0);
    check("rr_req", imem_req, 1);
    check("rr_addr", imem_addr, 32'h0000_0200);
    exp_q = '{32'h200, 32'h204};
    drain("rr_drain", 20);

    // redirect target alignment and address hold, table driven
    do_reset();
    inst_ready = 1'b1;
    tick();
    foreach (vt[i]) begin
      gnt_en = vt[i].gnt;
      tick();
      gnt_en          = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = vt[i].target;
      tick();
      redirect_valid = 1'b0;
      check($sformatf("vec%0d_req", i), imem_req, vt[i].exp_req);
      check($sformatf("vec%0d_addr", i), imem_addr, vt[i].exp_addr);
      check($sformatf("vec%0d_valid", i), inst_valid, 0);
      tick();
      check($sformatf("vec%0d_req1", i), imem_req, 1);
      check($sformatf("vec%0d_hold", i), imem_addr, vt[i].exp_addr);
    end

`ifdef FETCH_PERF_EN
    // 3 redirect cycles, 5 starved cycles after BOOT
    do_reset();
    tick();
    check("perf_boot_stall", psc1, 32'h0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    repeat (3) tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    check("perf_redirect", prc1, 32'd3);
    check("perf_stall", psc1, 32'd5);
`endif

    // asynchronous reset in the middle of fetching
    do_reset();
    gnt_en = 1'b1;
    repeat (6) tick();
    check("mid_pre_valid", inst_valid, 1);
    RESET_N = 1'b0;
    #1;
    chk_reset_vals("mid");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
